div_nonrestoring_seq: RTL and testbench
=======================================

# div_nonrestoring_seq

Multi-cycle signed integer divider for the ALU DIV operation. It computes quotient and remainder by iterated add/subtract, one quotient bit per clock, using a non-restoring recurrence. Quotient goes to LO and remainder to HI. It sits beside the adder/subtractor datapath in the ALU and is sequenced by the control unit through a start/done handshake.

## Interface
- WIDTH, 32, operand/result width in bits; recurrence iterations = WIDTH
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state and outputs
- start  input  1  one-cycle request; sampled only in IDLE
- dividend  input  WIDTH  signed two's complement; sampled on the start edge
- divisor  input  WIDTH  signed two's complement; sampled on the start edge
- busy  output  1  high from the edge after start is accepted until done is asserted
- done  output  1  one-cycle pulse; quotient/remainder are valid in the same cycle
- quotient  output  WIDTH  signed quotient, truncated toward zero (LO)
- remainder  output  WIDTH  signed remainder, sign of the dividend (HI)
- div_by_zero  output  1  set with done when divisor was 0; cleared on the next accepted start

## Operation
- States: IDLE, ITER, CORRECT, SIGN, DZERO.
- **IDLE, start=1:**
  - Latch sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
  - Latch magnitudes |dividend| -> Q register and |divisor| -> M register (WIDTH+1 bits, zero-extended).
  - Clear partial remainder A (WIDTH+1 bits); count = 0; clear div_by_zero.
  - If divisor==0, go to DZERO; else go to ITER.
- **IDLE, start=0:** stay in IDLE; outputs hold.
- **ITER, per edge:**
  - Shift {A,Q} left by 1.
  - If A (before the shift) ≥ 0, A = A − M; else A = A + M.
  - Q[0] = ~A_new[MSB].
  - count++. After WIDTH iterations, go to CORRECT.
- **CORRECT:** if A < 0, A = A + M. Go to SIGN.
- **SIGN:**
  - quotient = sign_q ? −Q : Q.
  - remainder = sign_r ? −A[WIDTH−1:0] : A[WIDTH−1:0].
  - done = 1. Go to IDLE.
- **DZERO:** quotient = all ones, remainder = latched dividend, div_by_zero = 1, done = 1. Go to IDLE.
- **Magnitude and overflow rules:**
  - |−2^(WIDTH−1)| is taken as unsigned 2^(WIDTH−1); the unsigned magnitude path is exact.
  - Overflow case −2^(WIDTH−1) / −1 gives quotient 0x80000000 (wraps) and remainder 0, with no flag.
- **Arithmetic width:** all add/sub in the recurrence is WIDTH+1 bits, two's complement. Negation is ~x+1, truncated to WIDTH.
- **start while busy:** ignored; operands are not resampled.
- **reset (any state, including mid-ITER):**
  - Next edge: state = IDLE; count, A, Q, M = 0.
  - quotient = 0, remainder = 0, busy = 0, done = 0, div_by_zero = 0.
  - Any in-flight result is discarded with no done pulse.
  - reset dominates start on the same edge.

## Timing
- Label the edge that accepts start as E0.
- **Normal divide:**
  - busy = 1 after E0.
  - ITER occupies edges E1..E(WIDTH).
  - CORRECT at E(WIDTH+1).
  - SIGN at E(WIDTH+2), which registers the outputs and done.
  - done is high for the cycle following E(WIDTH+2): 35 cycles after E0 for WIDTH=32.
- **Divide by zero:** DZERO at E1; done is high for the cycle following E1.
- busy falls on the same edge that raises done. busy and done are never both high.
- **Back-to-back requests:** start may be asserted in the done cycle. It is accepted, since the state is IDLE, and that edge is the new E0.
- quotient, remainder and div_by_zero hold their values until the next done or reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Positive/positive:** 100 / 7 -> done at E0+35; quotient = 14, remainder = 2, div_by_zero = 0; busy high for exactly 34 cycles.
- **Mixed signs:**
  - −100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE.
  - 100 / −7 -> quotient 0xFFFFFFF2, remainder 2.
  - −100 / −7 -> quotient 14, remainder 0xFFFFFFFE.
- **Overflow and extremes:**
  - 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
  - 0xFFFFFFFF / 0x80000000 -> quotient 0, remainder 0xFFFFFFFF.
- **Divide by zero:** 5 / 0 -> done at E0+2; quotient 0xFFFFFFFF, remainder 5, div_by_zero = 1. A following 9 / 3 -> quotient 3, remainder 0, div_by_zero = 0.
- **Reset mid-op:** start 1000 / 10, assert reset at E0+10 for 1 cycle.
  - All outputs are 0 the next cycle and no done pulse appears.
  - A new start with 1000 / 10 -> done 35 cycles later; quotient 100, remainder 0.
- **Handshake abuse:**
  - start held high for the whole operation 50 / 5: only one result (quotient 10) is produced; the next start is accepted in the done cycle.
  - Operand changes while busy do not affect the result.

Source files
------------

// File: rtl/div_nonrestoring_seq_if.sv
// Start/done handshake and operand/result bus for the sequential signed divider.
interface div_nonrestoring_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_nonrestoring_seq.sv
// Multi-cycle signed divider: non-restoring recurrence on magnitudes, one quotient
// bit per clock, then remainder correction and sign fix-up (quotient->LO, remainder->HI).
module div_nonrestoring_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    div_nonrestoring_seq_if.slave  bus
);
    localparam int unsigned AW = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ITER,
        S_CORRECT,
        S_SIGN,
        S_DZERO
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_count, w_count_nxt;
    logic [AW-1:0]    r_a, w_a_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [AW-1:0]    r_m, w_m_nxt;
    logic             r_sign_q, w_sign_q_nxt;
    logic             r_sign_r, w_sign_r_nxt;
    logic [WIDTH-1:0] r_dividend, w_dividend_nxt;
    logic [WIDTH-1:0] r_quotient, w_quotient_nxt;
    logic [WIDTH-1:0] r_remainder, w_remainder_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_dbz, w_dbz_nxt;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [AW-1:0]    w_a_sh;
    logic [AW-1:0]    w_a_step;

    // Most-negative operand maps to its exact unsigned magnitude
    assign w_dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
    assign w_dvs_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor  + WIDTH'(1)) : bus.divisor;

    // One recurrence step: shift {A,Q} left, then subtract or add M by sign of old A
    assign w_a_sh   = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_a_step = r_a[WIDTH] ? (w_a_sh + r_m) : (w_a_sh - r_m);

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_a_nxt         = r_a;
        w_q_nxt         = r_q;
        w_m_nxt         = r_m;
        w_sign_q_nxt    = r_sign_q;
        w_sign_r_nxt    = r_sign_r;
        w_dividend_nxt  = r_dividend;
        w_quotient_nxt  = r_quotient;
        w_remainder_nxt = r_remainder;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_dbz_nxt       = r_dbz;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_sign_q_nxt   = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    w_sign_r_nxt   = bus.dividend[WIDTH-1];
                    w_dividend_nxt = bus.dividend;
                    w_q_nxt        = w_dvd_mag;
                    w_m_nxt        = {1'b0, w_dvs_mag};
                    w_a_nxt        = '0;
                    w_count_nxt    = '0;
                    w_dbz_nxt      = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = (bus.divisor == '0) ? S_DZERO : S_ITER;
                end
            end
            S_ITER: begin
                w_a_nxt     = w_a_step;
                w_q_nxt     = {r_q[WIDTH-2:0], ~w_a_step[WIDTH]};
                w_count_nxt = r_count + CW'(1);
                if (r_count == CW'(WIDTH - 1)) begin
                    w_state_nxt = S_CORRECT;
                end
            end
            S_CORRECT: begin
                if (r_a[WIDTH]) begin
                    w_a_nxt = r_a + r_m;
                end
                w_state_nxt = S_SIGN;
            end
            S_SIGN: begin
                w_quotient_nxt  = r_sign_q ? (~r_q + WIDTH'(1)) : r_q;
                w_remainder_nxt = r_sign_r ? (~r_a[WIDTH-1:0] + WIDTH'(1)) : r_a[WIDTH-1:0];
                w_done_nxt      = 1'b1;
                w_busy_nxt      = 1'b0;
                w_state_nxt     = S_IDLE;
            end
            S_DZERO: begin
                w_quotient_nxt  = '1;
                w_remainder_nxt = r_dividend;
                w_dbz_nxt       = 1'b1;
                w_done_nxt      = 1'b1;
                w_busy_nxt      = 1'b0;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_a         <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dividend  <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_a         <= w_a_nxt;
            r_q         <= w_q_nxt;
            r_m         <= w_m_nxt;
            r_sign_q    <= w_sign_q_nxt;
            r_sign_r    <= w_sign_r_nxt;
            r_dividend  <= w_dividend_nxt;
            r_quotient  <= w_quotient_nxt;
            r_remainder <= w_remainder_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_dbz       <= w_dbz_nxt;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_div_nonrestoring_seq.sv
// Directed scoreboard bench for div_nonrestoring_seq: results, latency, busy span,
// divide-by-zero, mid-operation reset and start-while-busy handling.
module tb_div_nonrestoring_seq;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_nonrestoring_seq_if #(.WIDTH(W)) bus();

    div_nonrestoring_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference result from 64-bit signed arithmetic (truncating division)
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sd;
        sa = $signed(a);
        sd = $signed(b);
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = W'(sa / sd);
            e.r   = W'(sa % sd);
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit track, input bit hold);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (track) sb.push_back(model(a, b));
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
    endtask

    // Called at the first negedge after the accepting edge; returns at the done negedge
    task automatic wait_result(input string tag, input int exp_lat, input int exp_busy);
        int   cyc;
        int   nb;
        exp_t e;
        cyc = 1;
        nb  = 0;
        while (!bus.done && cyc < 100) begin
            if (bus.busy) nb++;
            @(negedge clk);
            cyc++;
        end
        if (!bus.done) begin
            chk({tag, "_timeout"}, 32'(bus.done), 32'd1);
            return;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_busycycles"}, 32'(nb), 32'(exp_busy));
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_done"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_quotient"}, bus.quotient, e.q);
        chk({tag, "_remainder"}, bus.remainder, e.r);
        chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(e.dbz));
    endtask

    task automatic idle_check(input string tag, input int n);
        int pulses;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        chk(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_quotient", bus.quotient, '0);
        chk("rst_remainder", bus.remainder, '0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        reset = 1'b0;

        start_op(32'd100, 32'd7, 1, 0);
        wait_result("pp_100_7", 35, 34);
        start_op(-32'sd100, 32'sd7, 1, 0);
        wait_result("np_100_7", 35, 34);
        start_op(32'sd100, -32'sd7, 1, 0);
        wait_result("pn_100_7", 35, 34);
        start_op(-32'sd100, -32'sd7, 1, 0);
        wait_result("nn_100_7", 35, 34);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        wait_result("ovf_min_m1", 35, 34);
        start_op(32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        wait_result("m1_min", 35, 34);

        start_op(32'd5, 32'd0, 1, 0);
        wait_result("dz_5_0", 2, 1);
        start_op(32'd9, 32'd3, 1, 0);
        wait_result("after_dz_9_3", 35, 34);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 3) rb = rb >> 20;
            start_op(ra, rb, 1, 0);
            wait_result("rand", 35, 34);
        end

        // Reset partway through an operation discards it
        start_op(32'd1000, 32'd10, 0, 0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_quotient", bus.quotient, '0);
        chk("midrst_remainder", bus.remainder, '0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
        reset = 1'b0;
        idle_check("midrst_no_done", 45);
        start_op(32'd1000, 32'd10, 1, 0);
        wait_result("after_rst_1000_10", 35, 34);

        // start held high and operands changed while busy
        start_op(32'd50, 32'd5, 1, 1);
        bus.dividend = 32'd999;
        bus.divisor  = 32'd3;
        repeat (5) @(negedge clk);
        bus.dividend = 32'd77;
        bus.divisor  = 32'd7;
        wait_result("hold_50_5", 30, 29);
        sb.push_back(model(32'd77, 32'd7));
        @(negedge clk);
        bus.start = 1'b0;
        wait_result("b2b_77_7", 35, 34);
        idle_check("b2b_no_extra_done", 40);
        chk("hold_outputs_q", bus.quotient, 32'd11);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
